// File: rtl/lsu_mem_port_if.sv
// Handshake bundles for lsu_mem_port: the core request/response channel
// (core = master) and the data-memory channel (LSU = master).
interface lsu_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              resp_misalign;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_misalign
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_misalign
    );
endinterface

interface lsu_dmem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic              MemWrite;
    logic              MemRead;
    logic [XLEN-1:0]   Write_data;
    logic [XLEN/8-1:0] Write_strb;
    logic              Mem_Req_Ready;
    logic [XLEN-1:0]   Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;

    modport master (
        output Address, MemWrite, MemRead, Write_data, Write_strb,
        output Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  Address, MemWrite, MemRead, Write_data, Write_strb,
        input  Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between EX and the data-memory handshake channel.
// Define MISALIGN_SPLIT_EN to split boundary-crossing accesses into two beats.
module lsu_mem_port #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_core_if.slave  core,
    lsu_dmem_if.master mem
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
`ifdef MISALIGN_SPLIT_EN
    localparam int SW = 2 * NB;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RDW, S_RESP, S_REQ2, S_RDW2
    } state_t;
`else
    localparam int SW = NB;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RDW, S_RESP
    } state_t;
`endif

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OFFW-1:0]   off_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              misalign_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     strb_q;
    logic              rd_ready_q;
`ifdef MISALIGN_SPLIT_EN
    logic              cross_q;
    logic [NB-1:0]     strb_hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              cross_d;
    logic [2*XLEN-1:0] ldw;
`endif

    logic [OFFW-1:0]   in_off;
    int                nb_d;
    int                nbc_d;
    int                j;
    logic              bad_d;
    logic [SW-1:0]     span_d;
    logic [XLEN-1:0]   wrep_d;
    logic [XLEN-1:0]   ld_raw;
    logic [XLEN-1:0]   ext_d;

    always_comb begin
        in_off = core.req_addr[OFFW-1:0];
        nb_d   = 1 << core.req_size;
        nbc_d  = (nb_d > NB) ? NB : nb_d;
`ifdef MISALIGN_SPLIT_EN
        bad_d   = (XLEN == 32) && (core.req_size == 2'd3);
        cross_d = (int'(in_off) + nb_d) > NB;
`else
        bad_d = ((XLEN == 32) && (core.req_size == 2'd3))
             || ((int'(in_off) & (nb_d - 1)) != 0);
`endif
        span_d = '0;
        for (int k = 0; k < SW; k++) begin
            span_d[k] = (k >= int'(in_off))
                     && (k < int'(in_off) + nb_d);
        end
        // Rotating by the offset equals plain replication when aligned.
        wrep_d = '0;
        j      = 0;
        for (int i = 0; i < NB; i++) begin
            j = (i - int'(in_off)) & (nbc_d - 1);
            wrep_d[i*8 +: 8] = core.req_wdata[j*8 +: 8];
        end
    end

    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        ldw = (state_q == S_RDW2) ? {mem.Read_data, lo_q}
                                  : {{XLEN{1'b0}}, mem.Read_data};
        ld_raw = XLEN'(ldw >> {off_q, 3'b000});
`else
        ld_raw = mem.Read_data >> {off_q, 3'b000};
`endif
        unique case (size_q)
            2'd0: ext_d = uns_q ? XLEN'(ld_raw[7:0])
                                : XLEN'($signed(ld_raw[7:0]));
            2'd1: ext_d = uns_q ? XLEN'(ld_raw[15:0])
                                : XLEN'($signed(ld_raw[15:0]));
            2'd2: ext_d = uns_q ? XLEN'(ld_raw[31:0])
                                : XLEN'($signed(ld_raw[31:0]));
            default: ext_d = ld_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            resp_data_q  <= '0;
            addr_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            rd_ready_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            cross_q      <= 1'b0;
            strb_hi_q    <= '0;
            lo_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: if (core.req_valid) begin
                    we_q        <= core.req_we;
                    size_q      <= core.req_size;
                    uns_q       <= core.req_unsigned;
                    off_q       <= in_off;
                    req_ready_q <= 1'b0;
                    if (bad_d) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        misalign_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        state_q     <= S_REQ;
                        mem_read_q  <= !core.req_we;
                        mem_write_q <= core.req_we;
                        addr_q      <= {core.req_addr[ADDR_W-1:OFFW],
                                        {OFFW{1'b0}}};
                        strb_q      <= span_d[NB-1:0];
                        wdata_q     <= core.req_we ? wrep_d : '0;
`ifdef MISALIGN_SPLIT_EN
                        cross_q     <= cross_d;
                        strb_hi_q   <= span_d[SW-1:NB];
`endif
                    end
                end
                S_REQ: if (mem.Mem_Req_Ready) begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (!we_q) begin
                        state_q    <= S_RDW;
                        rd_ready_q <= 1'b1;
                    end
`ifdef MISALIGN_SPLIT_EN
                    else if (cross_q) begin
                        state_q     <= S_REQ2;
                        mem_write_q <= 1'b1;
                        addr_q      <= addr_q + ADDR_W'(NB);
                        strb_q      <= strb_hi_q;
                    end
`endif
                    else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                    end
                end
                S_RDW: if (mem.Read_data_Valid) begin
                    rd_ready_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_q    <= S_REQ2;
                        mem_read_q <= 1'b1;
                        addr_q     <= addr_q + ADDR_W'(NB);
                        strb_q     <= strb_hi_q;
                        lo_q       <= mem.Read_data;
                    end else
`endif
                    begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= ext_d;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                S_REQ2: if (mem.Mem_Req_Ready) begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (!we_q) begin
                        state_q    <= S_RDW2;
                        rd_ready_q <= 1'b1;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                    end
                end
                S_RDW2: if (mem.Read_data_Valid) begin
                    rd_ready_q   <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= ext_d;
                end
`endif
                S_RESP: if (core.resp_ready) begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    misalign_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core.req_ready     = req_ready_q;
    assign core.resp_valid    = resp_valid_q;
    assign core.resp_data     = resp_data_q;
    assign core.resp_misalign = misalign_q;
    assign mem.Address         = addr_q;
    assign mem.MemWrite        = mem_write_q;
    assign mem.MemRead         = mem_read_q;
    assign mem.Write_data      = wdata_q;
    assign mem.Write_strb      = strb_q;
    assign mem.Read_data_Ready = rd_ready_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port (XLEN=32, default build): byte-level
// memory reference model, randomized stalls and back-pressure.
module tb_lsu_mem_port;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_core_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) core ();
    lsu_dmem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mem ();

    lsu_mem_port #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .mem  (mem)
    );

    int n_chk  = 0;
    int n_fail = 0;

    resp_t rq[$];
    beat_t bq[$];

    logic [7:0] ref_mem [0:255];
    logic [7:0] dmem    [0:255];

    int mrdy_mode  = 0;
    int rd_dly_max = 0;
    int rr_mode    = 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, one access at a time.
    task automatic model(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, output resp_t r);
        int    n;
        bit    mis;
        beat_t b;
        logic [31:0] v;
        n   = 1 << sz;
        mis = (sz == 2'd3) || ((a % n) != 0);
        r.data = '0;
        r.mis  = mis;
        if (!mis) begin
            b.we   = we;
            b.addr = a & ~32'h3;
            b.strb = '0;
            b.data = '0;
            for (int k = 0; k < n; k++) b.strb[(a + k) % 4] = 1'b1;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    b.data[i*8 +: 8] = wd[(i % n)*8 +: 8];
                for (int k = 0; k < n; k++)
                    ref_mem[(a + k) & 255] = wd[k*8 +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++)
                    v[k*8 +: 8] = ref_mem[(a + k) & 255];
                if (!uns && n < 4 && v[n*8-1])
                    for (int t = n * 8; t < 32; t++) v[t] = 1'b1;
                r.data = v;
            end
            bq.push_back(b);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input int lat,
                         input bit dexp, input logic [31:0] edat,
                         input logic emis);
        resp_t r;
        int    w;
        int    cyc;
        model(we, sz, uns, a, wd, r);
        if (dexp) begin
            r.data = edat;
            r.mis  = emis;
        end
        rq.push_back(r);
        @(posedge clk);
        #1;
        core.req_valid    = 1'b1;
        core.req_we       = we;
        core.req_size     = sz;
        core.req_unsigned = uns;
        core.req_addr     = a;
        core.req_wdata    = wd;
        w = 0;
        @(negedge clk);
        while (!core.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!core.req_ready) chk("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        core.req_valid    = 1'b0;
        core.req_we       = 1'($urandom);
        core.req_size     = 2'($urandom);
        core.req_unsigned = 1'($urandom);
        core.req_addr     = $urandom;
        core.req_wdata    = $urandom;
        if (lat > 0) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!core.resp_valid && cyc < 50);
            chk("latency", 64'(cyc), 64'(lat));
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((rq.size() != 0 || !core.req_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_resp_queue", 64'(rq.size()), 64'd0);
    endtask

    initial begin
        core.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core.resp_ready = (rr_mode == 1) ? 1'b1
                            : ($urandom_range(0, 3) != 0);
        end
    end

    // Memory responder: applies stores, returns reads, checks each beat.
    initial begin
        bit          pend;
        int          dly;
        int          b;
        logic [31:0] pa;
        logic        prq;
        logic        pacc;
        logic        req;
        logic        acc;
        logic [70:0] pvec;
        beat_t       e;
        pend = 0;
        dly  = 0;
        pa   = '0;
        prq  = 1'b0;
        pacc = 1'b0;
        pvec = '0;
        mem.Mem_Req_Ready   = 1'b0;
        mem.Read_data_Valid = 1'b0;
        mem.Read_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            case (mrdy_mode)
                1:       mem.Mem_Req_Ready = 1'b1;
                2:       mem.Mem_Req_Ready = 1'b0;
                default: mem.Mem_Req_Ready = ($urandom_range(0, 9) < 7);
            endcase
            if (pend && !mem.Read_data_Valid) begin
                if (dly == 0) begin
                    b = int'(pa[7:0]);
                    mem.Read_data_Valid = 1'b1;
                    mem.Read_data = {dmem[b+3], dmem[b+2],
                                     dmem[b+1], dmem[b]};
                end else begin
                    dly--;
                end
            end
            if (!pend) begin
                mem.Read_data_Valid = 1'b0;
                mem.Read_data       = $urandom;
            end
            @(negedge clk);
            if (!rst) begin
                pend = 0;
                prq  = 1'b0;
                pacc = 1'b0;
            end else begin
                req = mem.MemRead | mem.MemWrite;
                if (prq && !pacc && req)
                    chk("mem_req_hold",
                        {mem.MemRead, mem.MemWrite, mem.Address[31:0],
                         mem.Write_strb, mem.Write_data},
                        pvec);
                acc = req && mem.Mem_Req_Ready;
                if (acc) begin
                    if (bq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr %h rd %b wr %b expected no traffic",
                                 mem.Address, mem.MemRead, mem.MemWrite);
                    end else begin
                        e = bq.pop_front();
                        chk("beat_we", 64'(mem.MemWrite), 64'(e.we));
                        chk("beat_rd", 64'(mem.MemRead), 64'(!e.we));
                        chk("beat_addr", 64'(mem.Address), 64'(e.addr));
                        if (e.we) begin
                            chk("beat_strb", 64'(mem.Write_strb), 64'(e.strb));
                            chk("beat_wdata", 64'(mem.Write_data), 64'(e.data));
                            b = int'(mem.Address[7:0]);
                            for (int i = 0; i < 4; i++)
                                if (mem.Write_strb[i])
                                    dmem[b+i] = mem.Write_data[i*8 +: 8];
                        end else begin
                            pend = 1;
                            dly  = $urandom_range(0, rd_dly_max);
                            pa   = mem.Address;
                        end
                    end
                end
                if (mem.Read_data_Valid && mem.Read_data_Ready) pend = 0;
                prq  = req;
                pacc = acc;
                pvec = {mem.MemRead, mem.MemWrite, mem.Address[31:0],
                        mem.Write_strb, mem.Write_data};
            end
        end
    end

    // Response monitor: pops the scoreboard on every resp handshake.
    initial begin
        logic        pv;
        logic        phs;
        logic        hs;
        logic [31:0] pd;
        logic        pm;
        resp_t       e;
        pv  = 1'b0;
        phs = 1'b0;
        pd  = '0;
        pm  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv  = 1'b0;
                phs = 1'b0;
            end else begin
                if (phs)
                    chk("req_ready_after_resp",
                        {core.req_ready, core.resp_valid}, 2'b10);
                if (core.resp_valid && pv && !phs)
                    chk("resp_hold", {core.resp_data, core.resp_misalign},
                        {pd, pm});
                hs = core.resp_valid && core.resp_ready;
                if (hs) begin
                    chk("req_ready_low_in_resp", 64'(core.req_ready), 64'd0);
                    if (rq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got %h expected none",
                                 core.resp_data);
                    end else begin
                        e = rq.pop_front();
                        chk("resp_data", 64'(core.resp_data), 64'(e.data));
                        chk("resp_misalign", 64'(core.resp_misalign),
                            64'(e.mis));
                    end
                end
                pv  = core.resp_valid;
                phs = hs;
                pd  = core.resp_data;
                pm  = core.resp_misalign;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] wd;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        we;
        logic        uns;
        byte unsigned v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            dmem[i]    = v;
        end
        rst               = 1'b0;
        core.req_valid    = 1'b0;
        core.req_we       = 1'b0;
        core.req_size     = 2'd0;
        core.req_unsigned = 1'b0;
        core.req_addr     = '0;
        core.req_wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl",
            {core.req_ready, core.resp_valid, core.resp_misalign,
             mem.MemRead, mem.MemWrite, mem.Read_data_Ready},
            6'b100000);
        chk("reset_data",
            {core.resp_data, mem.Address[31:0]}, 64'd0);
        chk("reset_wr", {mem.Write_data, mem.Write_strb}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        mrdy_mode  = 1;
        rd_dly_max = 0;
        rr_mode    = 1;

        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 2,
              1'b1, 32'h0, 1'b0);
        drain();

        ref_mem[0] = 8'h00; dmem[0] = 8'h00;
        ref_mem[1] = 8'h00; dmem[1] = 8'h00;
        ref_mem[2] = 8'hFF; dmem[2] = 8'hFF;
        ref_mem[3] = 8'h80; dmem[3] = 8'h80;
        issue(1'b0, 2'd0, 1'b0, 32'h103, $urandom, 3,
              1'b1, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h103, $urandom, 3,
              1'b1, 32'h0000_0080, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h102, $urandom, 3,
              1'b1, 32'hFFFF_80FF, 1'b0);
        drain();

        mrdy_mode = 2;
        wd = $urandom;
        wd[15:0] = 16'hBEEF;
        issue(1'b1, 2'd1, 1'b0, 32'h102, wd, 0, 1'b1, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_memwrite", 64'(mem.MemWrite), 64'd1);
            chk("stall_wdata", 64'(mem.Write_data), 64'hBEEF_BEEF);
            chk("stall_strb", 64'(mem.Write_strb), 64'hC);
            chk("stall_addr", 64'(mem.Address), 64'h100);
        end
        mrdy_mode = 1;
        drain();

        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h102, $urandom, 1, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        drain();

        mrdy_mode  = 0;
        rd_dly_max = 3;
        rr_mode    = 0;
        for (int t = 0; t < 400; t++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom);
            a   = 32'h100 + 32'($urandom_range(0, 63));
            wd  = $urandom;
            issue(we, sz, uns, a, wd, 0, 1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        mrdy_mode  = 1;
        rd_dly_max = 0;
        rr_mode    = 1;
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rdw_pending",
            {mem.Read_data_Ready, mem.Read_data_Valid}, 2'b11);
        @(negedge clk);
        chk("reset_in_rdw",
            {core.req_ready, mem.Read_data_Ready, core.resp_valid,
             mem.MemRead},
            4'b1000);
        rq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        issue(1'b0, 2'd2, 1'b1, 32'h108, 32'h0, 3, 1'b0, 32'h0, 1'b0);
        drain();
        chk("beats_left", 64'(bq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
